// File: rtl/inst_buffer.sv
// inst_buffer: circular instruction queue between fetch and decode.
// Fetch enqueues up to FETCH_WIDTH contiguous instructions per cycle. Decode sees
// the oldest FETCH_WIDTH entries as a bundle, and those entries are consumed only
// in cycles where decode actually latches the bundle. A backend redirect flushes
// the buffer. A commit walk holds the bundle in place.
module inst_buffer #(
  parameter int FETCH_WIDTH = 4,
  parameter int DEPTH       = 16,
  parameter int FSQ_INFO_W  = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  // fetch side
  input  logic [FETCH_WIDTH-1:0]                in_en,
  input  logic [FETCH_WIDTH-1:0][31:0]          in_inst,
  input  logic [FETCH_WIDTH-1:0]                in_iam,
  input  logic [FETCH_WIDTH-1:0]                in_ipf,
  input  logic [FETCH_WIDTH-1:0][FSQ_INFO_W-1:0] in_fsqInfo,
  output logic                                  in_ready,
  // decode side (FetchBundle)
  output logic [FETCH_WIDTH-1:0]                out_en,
  output logic [FETCH_WIDTH-1:0][31:0]          out_inst,
  output logic [FETCH_WIDTH-1:0]                out_iam,
  output logic [FETCH_WIDTH-1:0]                out_ipf,
  output logic [FETCH_WIDTH-1:0][FSQ_INFO_W-1:0] out_fsqInfo,
  // backend control
  input  logic                                  rename_full,
  input  logic                                  dis_full,
  input  logic                                  redirect,
  input  logic                                  walk,
  // perf event: a walk is holding back instructions that are ready for decode
  output logic                                  walk_stall
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int LIDX_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

  typedef struct packed {
    logic [31:0]           inst;
    logic                  iam;
    logic                  ipf;
    logic [FSQ_INFO_W-1:0] fsq;
  } entry_t;

  // Storage is not reset. Only entries below count are ever presented as valid.
  entry_t mem [DEPTH];

  // Each pointer carries a wrap bit above the index.
  logic [PTR_W:0]   head_reg, head_next;
  logic [PTR_W:0]   tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic [CNT_W-1:0] enq_num;   // popcount of in_en
  logic [CNT_W-1:0] deq_num;   // min(count, FETCH_WIDTH)
  logic [CNT_W-1:0] enq_n;
  logic [CNT_W-1:0] deq_n;
  logic             enq_fire;
  logic             deq_fire;

  entry_t           in_data [FETCH_WIDTH];
  logic             wr_hit  [DEPTH];
  logic [LIDX_W-1:0] wr_lane [DEPTH];

  // in_ready depends only on the registered count, so it has no combinational input path.
  assign in_ready = (count_reg <= CNT_W'(DEPTH - FETCH_WIDTH));

  // Enqueue is blocked by a redirect in the same cycle. Dequeue happens exactly
  // when decode latches the bundle.
  assign enq_fire = (|in_en) & in_ready & ~redirect;
  assign deq_fire = ~(rename_full | dis_full) & ~walk & ~redirect;

  // Count the active fetch lanes. Lanes are contiguous from lane 0, so a popcount is enough.
  always_comb begin
    enq_num = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      enq_num = enq_num + CNT_W'(in_en[i]);
    end
  end

  assign deq_num = (count_reg < CNT_W'(FETCH_WIDTH)) ? count_reg : CNT_W'(FETCH_WIDTH);
  assign enq_n   = enq_fire ? enq_num : '0;
  assign deq_n   = deq_fire ? deq_num : '0;

  // Next-state pointer and occupancy. A redirect flushes everything.
  always_comb begin
    head_next  = head_reg + (PTR_W + 1)'(deq_n);
    tail_next  = tail_reg + (PTR_W + 1)'(enq_n);
    count_next = count_reg + enq_n - deq_n;
    if (redirect) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end
  end

  // Pointer and count registers. Reset has priority over redirect, enqueue and dequeue.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Pack the per-lane fetch payload into entry records.
  for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_in_pack
    assign in_data[gi] = '{inst: in_inst[gi], iam: in_iam[gi], ipf: in_ipf[gi],
                           fsq: in_fsqInfo[gi]};
  end

  // Each entry decides on its own whether it falls inside the tail..tail+n-1
  // window and, if so, which fetch lane feeds it. This keeps packets that
  // straddle the wrap point free of special cases.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
    logic [PTR_W-1:0] offset;
    assign offset      = PTR_W'(gi) - tail_reg[PTR_W-1:0];
    assign wr_hit[gi]  = enq_fire & ~rst & (CNT_W'(offset) < enq_num);
    assign wr_lane[gi] = offset[LIDX_W-1:0];
  end

  // Entry writes. Each entry takes at most one lane per cycle.
  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (wr_hit[e]) begin
        mem[e] <= in_data[wr_lane[e]];
      end
    end
  end

  // Lane i shows entry head+i. The bundle comes straight from registered state.
  for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_out_lane
    logic [PTR_W-1:0] rd_idx;
    entry_t           rd_ent;
    assign rd_idx           = head_reg[PTR_W-1:0] + PTR_W'(gi);
    assign rd_ent           = mem[rd_idx];
    assign out_en[gi]       = (CNT_W'(gi) < count_reg);
    assign out_inst[gi]     = rd_ent.inst;
    assign out_iam[gi]      = rd_ent.iam;
    assign out_ipf[gi]      = rd_ent.ipf;
    assign out_fsqInfo[gi]  = rd_ent.fsq;
  end

  assign walk_stall = walk & out_en[0];

endmodule
